// File: rtl/ysyx_201979054_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package ysyx_201979054_arb_pkg;

    // Requester counts and their id widths
    localparam int N_RD  = 3;
    localparam int N_WR  = 2;
    localparam int RD_IW = 2;
    localparam int WR_IW = 1;

    // Read requester indices
    localparam int RD_ICACHE = 0;
    localparam int RD_DCACHE = 1;
    localparam int RD_NC     = 2;

    // Write requester indices
    localparam int WR_DCACHE = 0;
    localparam int WR_NC     = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/ysyx_201979054_rr_picker.sv
// Combinational round-robin picker: the search starts one past ptr and
// wraps; the first set request bit wins. With ptr = N-1 this degenerates
// to a plain lowest-index priority picker.
module ysyx_201979054_rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Scan from farthest to nearest so the nearest hit overwrites the rest
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[IW'(idx)]) begin
                gnt_idx = IW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_201979054_mem_arbiter.sv
// Arbitrates the single-outstanding AXI master between the cache refill,
// writeback and non-cacheable requesters. Writes have fixed priority over
// reads so a dirty writeback always reaches memory before the refill that
// displaced it; reads share the bus round-robin.
module ysyx_201979054_mem_arbiter
    import ysyx_201979054_arb_pkg::*;
#(
    parameter int N_RD_P = N_RD,
    parameter int N_WR_P = N_WR
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [N_RD_P-1:0] i_rd_req,
    input  logic [N_WR_P-1:0] i_wr_req,
    input  logic              i_read_last_axi,
    input  logic              i_b_resp_axi,
    output logic              o_start_read_axi,
    output logic              o_start_write_axi,
    output logic [RD_IW-1:0]  o_rd_id,
    output logic [WR_IW-1:0]  o_wr_id,
    output logic [N_RD_P-1:0] o_rd_done,
    output logic [N_WR_P-1:0] o_wr_done,
    output logic              o_busy,
    output logic              o_err
);

    arb_state_t        state, state_n;
    logic [N_RD_P-1:0] rd_pend, rd_cand, rd_clr;
    logic [N_WR_P-1:0] wr_pend, wr_cand, wr_clr;
    logic [RD_IW-1:0]  rr_ptr;
    logic [RD_IW-1:0]  rd_idx;
    logic [WR_IW-1:0]  wr_idx;
    logic              rd_vld, wr_vld;
    logic              rd_take, wr_take;
    logic              err_set;

    // A pulse arriving this cycle competes alongside already-latched ones
    assign rd_cand = rd_pend | i_rd_req;
    assign wr_cand = wr_pend | i_wr_req;

    ysyx_201979054_rr_picker #(.N(N_RD_P), .IW(RD_IW)) u_rd_pick (
        .req     (rd_cand),
        .ptr     (rr_ptr),
        .gnt_idx (rd_idx),
        .gnt_vld (rd_vld)
    );

    // Fixed pointer at the top index makes the search start at 0
    ysyx_201979054_rr_picker #(.N(N_WR_P), .IW(WR_IW)) u_wr_pick (
        .req     (wr_cand),
        .ptr     (WR_IW'(N_WR_P - 1)),
        .gnt_idx (wr_idx),
        .gnt_vld (wr_vld)
    );

    assign o_busy = (state != IDLE);

    // Next state, grants, issue pulses, completion routing and error detect
    always_comb begin
        state_n           = state;
        rd_take           = 1'b0;
        wr_take           = 1'b0;
        rd_clr            = '0;
        wr_clr            = '0;
        err_set           = 1'b0;
        o_start_read_axi  = 1'b0;
        o_start_write_axi = 1'b0;
        o_rd_done         = '0;
        o_wr_done         = '0;
        case (state)
            IDLE: begin
                err_set = i_read_last_axi | i_b_resp_axi;
                if (wr_vld) begin
                    wr_take = 1'b1;
                    wr_clr  = N_WR_P'(1) << wr_idx;
                    state_n = WR_ISSUE;
                end else if (rd_vld) begin
                    rd_take = 1'b1;
                    rd_clr  = N_RD_P'(1) << rd_idx;
                    state_n = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                o_start_read_axi = 1'b1;
                err_set          = i_read_last_axi | i_b_resp_axi;
                state_n          = RD_WAIT;
            end
            RD_WAIT: begin
                err_set = i_b_resp_axi;
                if (i_read_last_axi) begin
                    o_rd_done = N_RD_P'(1) << o_rd_id;
                    state_n   = IDLE;
                end
            end
            WR_ISSUE: begin
                o_start_write_axi = 1'b1;
                err_set           = i_read_last_axi | i_b_resp_axi;
                state_n           = WR_WAIT;
            end
            WR_WAIT: begin
                err_set = i_read_last_axi;
                if (i_b_resp_axi) begin
                    o_wr_done = N_WR_P'(1) << o_wr_id;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, pending latches, owner ids, RR pointer, sticky error
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            rd_pend <= '0;
            wr_pend <= '0;
            o_rd_id <= '0;
            o_wr_id <= '0;
            rr_ptr  <= '0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_n;
            rd_pend <= rd_cand & ~rd_clr;
            wr_pend <= wr_cand & ~wr_clr;
            if (rd_take) begin
                o_rd_id <= rd_idx;
                rr_ptr  <= rd_idx;
            end
            if (wr_take)
                o_wr_id <= wr_idx;
            if (err_set)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_201979054_mem_arbiter.sv
// Directed bench for the memory arbiter. Inputs change 2 time units after
// the rising edge; outputs are compared 1 unit after each input change.
module tb_ysyx_201979054_mem_arbiter;

    logic       clk = 1'b0;
    logic       arst;
    logic [2:0] i_rd_req;
    logic [1:0] i_wr_req;
    logic       i_read_last_axi;
    logic       i_b_resp_axi;
    logic       o_start_read_axi;
    logic       o_start_write_axi;
    logic [1:0] o_rd_id;
    logic [0:0] o_wr_id;
    logic [2:0] o_rd_done;
    logic [1:0] o_wr_done;
    logic       o_busy;
    logic       o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_201979054_mem_arbiter dut (
        .clk               (clk),
        .arst              (arst),
        .i_rd_req          (i_rd_req),
        .i_wr_req          (i_wr_req),
        .i_read_last_axi   (i_read_last_axi),
        .i_b_resp_axi      (i_b_resp_axi),
        .o_start_read_axi  (o_start_read_axi),
        .o_start_write_axi (o_start_write_axi),
        .o_rd_id           (o_rd_id),
        .o_wr_id           (o_wr_id),
        .o_rd_done         (o_rd_done),
        .o_wr_done         (o_wr_done),
        .o_busy            (o_busy),
        .o_err             (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in the ISSUE cycle; finishes in the first IDLE cycle after done
    task automatic do_rd(input string tag, input logic [1:0] id);
        #1;
        chk({tag, "_start"}, 32'(o_start_read_axi), 32'd1);
        chk({tag, "_id"}, 32'(o_rd_id), 32'(id));
        tick();
        tick();
        i_read_last_axi = 1'b1;
        #1;
        chk({tag, "_done"}, 32'(o_rd_done), 32'(3'b001 << id));
        tick();
        i_read_last_axi = 1'b0;
        #1;
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        arst = 1'b0;
        i_rd_req = '0;
        i_wr_req = '0;
        i_read_last_axi = 1'b0;
        i_b_resp_axi = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_outs", {o_start_read_axi, o_start_write_axi, o_rd_id, o_wr_id,
                         o_rd_done, o_wr_done, o_err}, 32'd0);
        arst = 1'b1;
        tick();

        // Single icache read: issue at t0+1, strobe at t0+5, idle at t0+6
        i_rd_req = 3'b001;
        #1;
        chk("t1_no_start_t0", 32'(o_start_read_axi), 32'd0);
        tick();
        i_rd_req = 3'b000;
        #1;
        chk("t1_start", 32'(o_start_read_axi), 32'd1);
        chk("t1_id", 32'(o_rd_id), 32'd0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        tick();
        chk("t1_start_once", 32'(o_start_read_axi), 32'd0);
        tick();
        tick();
        tick();
        i_read_last_axi = 1'b1;
        #1;
        chk("t1_done", 32'(o_rd_done), 32'd1);
        chk("t1_busy_done", 32'(o_busy), 32'd1);
        tick();
        i_read_last_axi = 1'b0;
        #1;
        chk("t1_idle", 32'(o_busy), 32'd0);
        chk("t1_done_clr", 32'(o_rd_done), 32'd0);

        // All three reads at once, rr_ptr=0 -> order 1,2,0
        i_rd_req = 3'b111;
        tick();
        i_rd_req = 3'b000;
        do_rd("rr_a", 2'd1);
        tick();
        do_rd("rr_b", 2'd2);
        tick();
        do_rd("rr_c", 2'd0);
        tick();
        chk("rr_empty", {31'd0, o_busy | o_start_read_axi}, 32'd0);
        tick();
        chk("rr_empty2", 32'(o_busy), 32'd0);

        // Write beats a simultaneous read
        i_wr_req = 2'b01;
        i_rd_req = 3'b010;
        tick();
        i_wr_req = 2'b00;
        i_rd_req = 3'b000;
        #1;
        chk("wr_start", 32'(o_start_write_axi), 32'd1);
        chk("wr_id", 32'(o_wr_id), 32'd0);
        chk("wr_no_rd", 32'(o_start_read_axi), 32'd0);
        tick();
        tick();
        chk("wr_rd_held", 32'(o_start_read_axi), 32'd0);
        i_b_resp_axi = 1'b1;
        #1;
        chk("wr_done", 32'(o_wr_done), 32'd1);
        chk("wr_no_rd_done", 32'(o_rd_done), 32'd0);
        tick();
        i_b_resp_axi = 1'b0;
        #1;
        chk("wr_idle", 32'(o_busy), 32'd0);
        tick();
        do_rd("wr_then_rd", 2'd1);

        // Re-pulse of dcache read during its own wait gives a second read
        tick();
        i_rd_req = 3'b010;
        tick();
        i_rd_req = 3'b000;
        #1;
        chk("rp_start", 32'(o_start_read_axi), 32'd1);
        chk("rp_id", 32'(o_rd_id), 32'd1);
        tick();
        i_rd_req = 3'b010;
        tick();
        i_rd_req = 3'b000;
        i_read_last_axi = 1'b1;
        #1;
        chk("rp_done1", 32'(o_rd_done), 32'b010);
        tick();
        i_read_last_axi = 1'b0;
        tick();
        do_rd("rp_second", 2'd1);
        chk("rp_err_clean", 32'(o_err), 32'd0);

        // Stray read-last in IDLE: ignored, sticky error
        i_read_last_axi = 1'b1;
        #1;
        chk("stray_no_done", 32'(o_rd_done), 32'd0);
        tick();
        i_read_last_axi = 1'b0;
        #1;
        chk("stray_idle", 32'(o_busy), 32'd0);
        chk("stray_err", 32'(o_err), 32'd1);
        tick();
        tick();
        chk("stray_err_sticky", 32'(o_err), 32'd1);

        // Reset during RD_WAIT with the nc read pending
        i_rd_req = 3'b001;
        tick();
        i_rd_req = 3'b000;
        #1;
        chk("mr_start", 32'(o_start_read_axi), 32'd1);
        chk("mr_id", 32'(o_rd_id), 32'd0);
        tick();
        i_rd_req = 3'b100;
        tick();
        i_rd_req = 3'b000;
        arst = 1'b0;
        #1;
        chk("mr_outs", {o_start_read_axi, o_start_write_axi, o_rd_id, o_wr_id,
                        o_rd_done, o_wr_done, o_busy, o_err}, 32'd0);
        tick();
        arst = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_no_issue", {30'd0, o_busy, o_start_read_axi}, 32'd0);

        // Both strobes in RD_WAIT: read completes, error flagged
        i_rd_req = 3'b100;
        tick();
        i_rd_req = 3'b000;
        #1;
        chk("both_id", 32'(o_rd_id), 32'd2);
        tick();
        i_read_last_axi = 1'b1;
        i_b_resp_axi = 1'b1;
        #1;
        chk("both_rd_done", 32'(o_rd_done), 32'b100);
        chk("both_wr_done", 32'(o_wr_done), 32'd0);
        tick();
        i_read_last_axi = 1'b0;
        i_b_resp_axi = 1'b0;
        #1;
        chk("both_idle", 32'(o_busy), 32'd0);
        chk("both_err", 32'(o_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
